// File: rtl/dvi_pixel_fetch.sv
// FIFO-to-DVI pixel stage: pops a first-word-fall-through colour FIFO during
// active video and drives a registered R/G/B bus into the DVI encoder.
// Starved pixels are shown as black or as a repeat of the last popped pixel.
// After a starve the stage can optionally drop the rest of the frame and
// realign on the next frame_start. Underrun status is sticky and saturating.
module dvi_pixel_fetch #(
   parameter int unsigned BPC           = 8,
   parameter int unsigned UNDERRUN_MODE = 0,
   parameter int unsigned RESYNC_EN     = 1,
   parameter int unsigned CNT_W         = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fifo_empty,
   input  logic [3*BPC-1:0]   fifo_data,
   output logic               fifo_rd_en,
   input  logic               blank,
   input  logic               frame_start,
   output logic [BPC-1:0]     pixel_r,
   output logic [BPC-1:0]     pixel_g,
   output logic [BPC-1:0]     pixel_b,
   output logic               pixel_valid,
   output logic               stall,
   output logic               underrun_sticky,
   output logic [CNT_W-1:0]   underrun_cnt,
   input  logic               clr_status
);

   localparam int unsigned PW = 3 * BPC;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      UNDERRUN = 2'd2,
      RESYNC   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    pix_q, pix_d;
   logic [PW-1:0]    last_q, last_d;
   logic             valid_q, valid_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             rd_en_c;
   logic             show_c;
   logic             event_c;

   // Next-state, pop decision, next pixel bus and status update
   always_comb begin
      state_d  = state_q;
      pix_d    = '0;
      valid_d  = 1'b0;
      last_d   = last_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      rd_en_c  = 1'b0;
      show_c   = 1'b0;
      event_c  = 1'b0;

      case (state_q)
         IDLE: begin
            // Only the first pixel of a frame can start the stream.
            if (blank && !fifo_empty && frame_start) begin
               rd_en_c = 1'b1;
               show_c  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (blank) begin
               if (fifo_empty) begin
                  event_c = 1'b1;
                  state_d = UNDERRUN;
               end else begin
                  rd_en_c = 1'b1;
                  show_c  = 1'b1;
               end
            end
         end
         UNDERRUN: begin
            if (blank && fifo_empty) begin
               event_c = 1'b1;
            end
            if (RESYNC_EN != 0) begin
               state_d = RESYNC;
            end else if (blank && !fifo_empty) begin
               // Resume immediately; the line shift is accepted.
               rd_en_c = 1'b1;
               show_c  = 1'b1;
               state_d = RUN;
            end
         end
         RESYNC: begin
            if (blank) begin
               if (!fifo_empty) begin
                  // Pops here are discards except on the frame boundary.
                  rd_en_c = 1'b1;
                  if (frame_start) begin
                     show_c  = 1'b1;
                     state_d = RUN;
                  end
               end else if (frame_start) begin
                  event_c = 1'b1;
                  state_d = UNDERRUN;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (show_c) begin
         pix_d   = fifo_data;
         valid_d = 1'b1;
         last_d  = fifo_data;
      end else if (event_c) begin
         pix_d = (UNDERRUN_MODE != 0) ? last_q : '0;
      end

      // A clear coincident with an event leaves exactly that event recorded.
      if (clr_status) begin
         cnt_d    = event_c ? CNT_W'(1) : '0;
         sticky_d = event_c;
      end else if (event_c) begin
         sticky_d = 1'b1;
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // State, pixel bus and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pix_q    <= '0;
         last_q   <= '0;
         valid_q  <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pix_q    <= pix_d;
         last_q   <= last_d;
         valid_q  <= valid_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign fifo_rd_en      = rd_en_c;
   assign stall           = fifo_empty;
   assign pixel_r         = pix_q[PW-1 -: BPC];
   assign pixel_g         = pix_q[2*BPC-1 -: BPC];
   assign pixel_b         = pix_q[BPC-1:0];
   assign pixel_valid     = valid_q;
   assign underrun_sticky = sticky_q;
   assign underrun_cnt    = cnt_q;

endmodule

// File: tb/tb_dvi_pixel_fetch.sv
// Bench for dvi_pixel_fetch: four instances with different underrun policies
// and counter widths share blank/frame_start/clr_status, each fed from its own
// FIFO emulation, and are compared every cycle against a behavioural model.
module tb_dvi_pixel_fetch;

   localparam int unsigned NI    = 4;
   localparam int unsigned DEPTH = 1024;

   logic clk;
   logic rst_n;
   logic blank;
   logic frame_start;
   logic clr_status;

   logic [NI-1:0] fifo_empty;
   logic [23:0]   fifo_data [NI];
   logic [NI-1:0] rd_en;
   logic [NI-1:0] stall;
   logic [NI-1:0] valid;
   logic [NI-1:0] sticky;
   logic [7:0]    pr [NI];
   logic [7:0]    pg [NI];
   logic [7:0]    pb [NI];
   logic [15:0]   cnt_w [NI];

   int n_tests;
   int n_fail;

   // Instance i: repeat-last = i%2, resync = i/2, 2-bit counter on instance 1
   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int unsigned UM = gi % 2;
      localparam int unsigned RE = gi / 2;
      localparam int unsigned CW = (gi == 1) ? 2 : 16;
      logic [CW-1:0] cnt_n;
      dvi_pixel_fetch #(
         .BPC(8), .UNDERRUN_MODE(UM), .RESYNC_EN(RE), .CNT_W(CW)
      ) u_dut (
         .clk             (clk),
         .rst_n           (rst_n),
         .fifo_empty      (fifo_empty[gi]),
         .fifo_data       (fifo_data[gi]),
         .fifo_rd_en      (rd_en[gi]),
         .blank           (blank),
         .frame_start     (frame_start),
         .pixel_r         (pr[gi]),
         .pixel_g         (pg[gi]),
         .pixel_b         (pb[gi]),
         .pixel_valid     (valid[gi]),
         .stall           (stall[gi]),
         .underrun_sticky (sticky[gi]),
         .underrun_cnt    (cnt_n),
         .clr_status      (clr_status)
      );
      assign cnt_w[gi] = 16'(cnt_n);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO emulation, one per instance
   logic [23:0] fbuf [NI][DEPTH];
   int          wp [NI];
   int          rp [NI];

   // Behavioural model: where each instance is in its frame
   bit          m_live   [NI];  // streaming pixels
   bit          m_hungry [NI];  // starved on the previous cycle
   bit          m_drop   [NI];  // dropping pixels until the next frame start
   logic [23:0] m_last   [NI];
   logic [23:0] ex_pix   [NI];
   logic        ex_val   [NI];
   int unsigned ex_cnt   [NI];
   logic        ex_sticky[NI];

   task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d]: got %0h expected %0h", tag, idx, obs, exp);
      end
   endtask

   function automatic logic [23:0] pix_of(input int i);
      return {pr[i], pg[i], pb[i]};
   endfunction

   task automatic refresh(input int i);
      fifo_empty[i] = (wp[i] == rp[i]);
      fifo_data[i]  = fbuf[i][rp[i] % DEPTH];
   endtask

   task automatic push_all(input logic [23:0] v);
      for (int i = 0; i < NI; i++) begin
         fbuf[i][wp[i] % DEPTH] = v;
         wp[i]++;
         refresh(i);
      end
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < NI; i++) begin
         m_live[i] = 0; m_hungry[i] = 0; m_drop[i] = 0;
         m_last[i] = '0; ex_pix[i] = '0; ex_val[i] = 1'b0;
         ex_cnt[i] = 0; ex_sticky[i] = 1'b0;
      end
   endtask

   // Expected pop strobe for the current inputs
   function automatic logic mdl_rd(input int i, input logic b, input logic f, input logic e);
      if (!b || e) return 1'b0;
      if (m_live[i] || m_drop[i]) return 1'b1;
      if (m_hungry[i]) return (i / 2) == 0;
      return f;
   endfunction

   // Advance the model by one clock edge
   task automatic mdl_update(input int i, input logic b, input logic f, input logic c,
                             input logic e, input logic [23:0] h);
      logic take, shown, ev;
      bit resync, rep_last;
      int unsigned cmax;
      resync   = (i / 2) == 1;
      rep_last = (i % 2) == 1;
      cmax     = (i == 1) ? 3 : 65535;
      take  = mdl_rd(i, b, f, e);
      shown = take && !(m_drop[i] && !f);
      ev    = b && e && (m_live[i] || m_hungry[i] || (m_drop[i] && f));

      ex_pix[i] = '0;
      ex_val[i] = 1'b0;
      if (shown) begin
         ex_pix[i] = h;
         ex_val[i] = 1'b1;
         m_last[i] = h;
      end else if (ev && rep_last) begin
         ex_pix[i] = m_last[i];
      end

      if (c) begin
         ex_cnt[i]    = ev ? 1 : 0;
         ex_sticky[i] = ev;
      end else if (ev) begin
         ex_sticky[i] = 1'b1;
         if (ex_cnt[i] < cmax) ex_cnt[i]++;
      end

      if (m_live[i]) begin
         if (ev) begin m_live[i] = 0; m_hungry[i] = 1; end
      end else if (m_hungry[i]) begin
         if (resync) begin m_hungry[i] = 0; m_drop[i] = 1; end
         else if (shown) begin m_hungry[i] = 0; m_live[i] = 1; end
      end else if (m_drop[i]) begin
         if (shown) begin m_drop[i] = 0; m_live[i] = 1; end
         else if (ev) begin m_drop[i] = 0; m_hungry[i] = 1; end
      end else if (shown) begin
         m_live[i] = 1;
      end
   endtask

   task automatic chk_outputs(input int i);
      chk("pixel", i, 32'(pix_of(i)), 32'(ex_pix[i]));
      chk("valid", i, 32'(valid[i]), 32'(ex_val[i]));
      chk("cnt", i, 32'(cnt_w[i]), ex_cnt[i]);
      chk("sticky", i, 32'(sticky[i]), 32'(ex_sticky[i]));
   endtask

   // One clock: check strobes before the edge, registers after it
   task automatic step();
      logic [NI-1:0] rd_s;
      logic [NI-1:0] e_s;
      logic [23:0]   h_s [NI];
      logic b, f, c;
      #1;
      b = blank; f = frame_start; c = clr_status;
      for (int i = 0; i < NI; i++) begin
         e_s[i] = fifo_empty[i];
         h_s[i] = fifo_data[i];
         rd_s[i] = rd_en[i];
         chk("rd_en", i, 32'(rd_en[i]), 32'(mdl_rd(i, b, f, e_s[i])));
         chk("stall", i, 32'(stall[i]), 32'(e_s[i]));
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         if (rd_s[i] && (rp[i] != wp[i])) rp[i]++;
         mdl_update(i, b, f, c, e_s[i], h_s[i]);
         chk_outputs(i);
         refresh(i);
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic b, input logic f, input logic c);
      blank = b; frame_start = f; clr_status = c;
      step();
   endtask

   task automatic do_reset();
      blank = 1'b0; frame_start = 1'b0; clr_status = 1'b0;
      rst_n = 1'b0;
      mdl_reset();
      #1;
      for (int i = 0; i < NI; i++) begin
         chk("rst_pixel", i, 32'(pix_of(i)), 32'h0);
         chk("rst_valid", i, 32'(valid[i]), 32'h0);
         chk("rst_cnt", i, 32'(cnt_w[i]), 32'h0);
         chk("rst_sticky", i, 32'(sticky[i]), 32'h0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [23:0] px;
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < NI; i++) begin
         wp[i] = 0; rp[i] = 0;
         refresh(i);
      end
      blank = 1'b0; frame_start = 1'b0; clr_status = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      do_reset();

      // Frame start with two pixels queued
      push_all(24'h112233);
      push_all(24'h445566);
      drive(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < NI; i++) chk("t1_px0", i, 32'(pix_of(i)), 32'h112233);
      drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < NI; i++) begin
         chk("t1_px1", i, 32'(pix_of(i)), 32'h445566);
         chk("t1_cnt", i, 32'(cnt_w[i]), 32'h0);
      end
      drive(1'b0, 1'b0, 1'b0);

      // Three starved active cycles after AABBCC, then 010203
      push_all(24'hAABBCC);
      drive(1'b1, 1'b0, 1'b0);
      repeat (3) drive(1'b1, 1'b0, 1'b0);
      chk("t2_black", 0, 32'(pix_of(0)), 32'h0);
      chk("t3_repeat", 1, 32'(pix_of(1)), 32'hAABBCC);
      chk("t2_cnt", 0, 32'(cnt_w[0]), 32'd3);
      chk("t3_cnt", 1, 32'(cnt_w[1]), 32'd3);
      push_all(24'h010203);
      drive(1'b1, 1'b0, 1'b0);
      chk("t2_resume", 0, 32'(pix_of(0)), 32'h010203);
      chk("t2_sticky", 0, 32'(sticky[0]), 32'h1);
      chk("t4_discard", 2, 32'(pix_of(2)), 32'h0);
      drive(1'b0, 1'b0, 1'b0);

      // Refill with ten pixels mid-frame, then realign on frame_start
      for (int k = 0; k < 10; k++) push_all(24'($urandom));
      repeat (10) drive(1'b1, 1'b0, 1'b0);
      repeat (2) drive(1'b0, 1'b0, 1'b0);
      px = 24'($urandom) | 24'h000001;
      push_all(px);
      drive(1'b1, 1'b1, 1'b0);
      chk("t4_shown", 2, 32'(pix_of(2)), 32'(px));
      chk("t4_valid", 2, 32'(valid[2]), 32'h1);
      drive(1'b0, 1'b0, 1'b0);

      // Blanking with data waiting: no pops, no status change
      push_all(24'h777777);
      push_all(24'h888888);
      repeat (5) drive(1'b0, 1'b0, 1'b0);
      repeat (2) drive(1'b1, 1'b0, 1'b0);

      // Counter saturation and clear behaviour
      drive(1'b0, 1'b0, 1'b1);
      repeat (5) drive(1'b1, 1'b0, 1'b0);
      chk("t6_sat", 1, 32'(cnt_w[1]), 32'd3);
      chk("t6_cnt5", 0, 32'(cnt_w[0]), 32'd5);
      drive(1'b1, 1'b0, 1'b1);
      chk("t6_clr_ev_cnt", 1, 32'(cnt_w[1]), 32'd1);
      chk("t6_clr_ev_sticky", 1, 32'(sticky[1]), 32'h1);
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < NI; i++) begin
         chk("t6_clr_cnt", i, 32'(cnt_w[i]), 32'h0);
         chk("t6_clr_sticky", i, 32'(sticky[i]), 32'h0);
      end

      // Randomized traffic with a mid-frame reset
      for (int n = 0; n < 400; n++) begin
         if (n == 200) do_reset();
         if ($urandom_range(0, 99) < 60) push_all(24'($urandom));
         blank       = ($urandom_range(0, 99) < 80);
         frame_start = blank && ($urandom_range(0, 99) < 6);
         clr_status  = ($urandom_range(0, 99) < 3);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
